// File: rtl/acl2_spi_responder.sv
// acl2_spi_responder: SPI mode-0 slave emulating the ADXL362 register protocol
//   sclk, rst          SPI clock (sole clock), asynchronous active-high reset
//   cs, mosi           active-low chip select, serial data in (MSB first)
//   miso, miso_oe      serial read data (MSB first) and its drive enable, launched on negedge
//   acc_x/y/z          signed 12-bit sample sources, snapshotted at each read command
//   power_ctl          register 0x2D; measuring is power_ctl[1:0]==2'b10
//   filter_ctl         register 0x2C
//   xfer_done          one-sclk pulse per completed data byte
module acl2_spi_responder #(
    parameter logic [7:0] DEVID_AD  = 8'hAD,
    parameter logic [7:0] DEVID_MST = 8'h1D,
    parameter logic [7:0] PARTID    = 8'hF2
) (
    input  logic               sclk,
    input  logic               rst,
    input  logic               cs,
    input  logic               mosi,
    output logic               miso,
    output logic               miso_oe,
    input  logic signed [11:0] acc_x,
    input  logic signed [11:0] acc_y,
    input  logic signed [11:0] acc_z,
    output logic [7:0]         power_ctl,
    output logic [7:0]         filter_ctl,
    output logic               measuring,
    output logic               xfer_done
);
    typedef enum logic [1:0] {S_CMD, S_ADDR, S_DATA, S_IGNORE} state_t;
    state_t      state, state_n;
    logic [2:0]  bitcnt;
    logic [6:0]  sh;
    logic [7:0]  rx, ptr, tx_byte, rd_addr, rd_data;
    logic [11:0] snap_x, snap_y, snap_z;
    logic        rd_mode, done, drive;
    assign rx        = {sh, mosi};
    assign done      = !cs && bitcnt == 3'd7;
    assign measuring = power_ctl[1:0] == 2'b10;
    // Read data is fetched for the address just received while in ADDR, else for ptr.
    assign rd_addr   = state == S_ADDR ? rx : ptr;
    assign drive     = !cs && state == S_DATA && rd_mode;
    always_ff @(posedge sclk or posedge rst)
        if (rst) state <= S_CMD;
        else     state <= state_n;
    always_comb begin
        state_n = state;
        if (cs)
            state_n = S_CMD;
        else if (done)
            case (state)
                S_CMD:   state_n = (rx == 8'h0A || rx == 8'h0B) ? S_ADDR : S_IGNORE;
                S_ADDR:  state_n = S_DATA;
                default: state_n = state;
            endcase
    end
    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            8'h00:   rd_data = DEVID_AD;
            8'h01:   rd_data = DEVID_MST;
            8'h02:   rd_data = PARTID;
            8'h08:   rd_data = measuring ? snap_x[11:4] : 8'h00;
            8'h09:   rd_data = measuring ? snap_y[11:4] : 8'h00;
            8'h0A:   rd_data = measuring ? snap_z[11:4] : 8'h00;
            8'h0B:   rd_data = {7'b0, measuring};
            8'h0E:   rd_data = measuring ? snap_x[7:0] : 8'h00;
            8'h0F:   rd_data = measuring ? {{4{snap_x[11]}}, snap_x[11:8]} : 8'h00;
            8'h10:   rd_data = measuring ? snap_y[7:0] : 8'h00;
            8'h11:   rd_data = measuring ? {{4{snap_y[11]}}, snap_y[11:8]} : 8'h00;
            8'h12:   rd_data = measuring ? snap_z[7:0] : 8'h00;
            8'h13:   rd_data = measuring ? {{4{snap_z[11]}}, snap_z[11:8]} : 8'h00;
            8'h2C:   rd_data = filter_ctl;
            8'h2D:   rd_data = power_ctl;
            default: rd_data = 8'h00;
        endcase
    end
    always_ff @(posedge sclk or posedge rst)
        if (rst) begin
            bitcnt     <= 3'd0;
            sh         <= 7'd0;
            ptr        <= 8'h00;
            tx_byte    <= 8'h00;
            rd_mode    <= 1'b0;
            xfer_done  <= 1'b0;
            power_ctl  <= 8'h00;
            filter_ctl <= 8'h13;
            snap_x     <= 12'd0;
            snap_y     <= 12'd0;
            snap_z     <= 12'd0;
        end else if (cs) begin
            bitcnt    <= 3'd0;
            xfer_done <= 1'b0;
        end else begin
            bitcnt    <= bitcnt + 3'd1;
            sh        <= {sh[5:0], mosi};
            xfer_done <= done && state == S_DATA;
            if (done)
                case (state)
                    S_CMD: begin
                        rd_mode <= rx == 8'h0B;
                        if (rx == 8'h0B) begin
                            snap_x <= acc_x;
                            snap_y <= acc_y;
                            snap_z <= acc_z;
                        end
                    end
                    S_ADDR: begin
                        ptr <= rd_mode ? rx + 8'd1 : rx;
                        if (rd_mode) tx_byte <= rd_data;
                    end
                    S_DATA: begin
                        ptr <= ptr + 8'd1;
                        if (rd_mode) tx_byte <= rd_data;
                        else if (ptr == 8'h2C) filter_ctl <= rx;
                        else if (ptr == 8'h2D) power_ctl <= rx;
                    end
                    default: ;
                endcase
        end
    // Launch on negedge so the master samples bit 7 on the first posedge of a data byte.
    always_ff @(negedge sclk or posedge rst)
        if (rst) begin
            miso    <= 1'b0;
            miso_oe <= 1'b0;
        end else begin
            miso    <= drive && tx_byte[3'd7 - bitcnt];
            miso_oe <= drive;
        end
endmodule

// File: tb/tb_acl2_spi_responder.sv
// tb_acl2_spi_responder: randomized and directed checks of acl2_spi_responder against a register-map model
module tb_acl2_spi_responder;
    logic        sclk = 0, rst = 1, cs = 1, mosi = 0;
    logic        miso, miso_oe, measuring, xfer_done;
    logic [11:0] acc_x = 0, acc_y = 0, acc_z = 0;
    logic [7:0]  power_ctl, filter_ctl;
    int          checks = 0, errors = 0, xd;
    logic [7:0]  m_power = 8'h00, m_filter = 8'h13;
    logic [7:0]  rxq[$];
    logic        oeq[$];
    acl2_spi_responder dut (
        .sclk(sclk), .rst(rst), .cs(cs), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
        .acc_x(acc_x), .acc_y(acc_y), .acc_z(acc_z), .power_ctl(power_ctl),
        .filter_ctl(filter_ctl), .measuring(measuring), .xfer_done(xfer_done)
    );
    always #5 sclk = ~sclk;
    // Register-map reference: what the ADXL362 returns at address a for a given sample snapshot.
    function automatic logic [7:0] m_rd(input logic [7:0] a, input logic [11:0] x, y, z);
        logic        meas;
        logic [11:0] v;
        int          idx;
        meas = m_power[1:0] == 2'b10;
        if (a == 8'h00) return 8'hAD;
        if (a == 8'h01) return 8'h1D;
        if (a == 8'h02) return 8'hF2;
        if (a == 8'h0B) return {7'b0, meas};
        if (a == 8'h2C) return m_filter;
        if (a == 8'h2D) return m_power;
        if (!meas) return 8'h00;
        if (a >= 8'h08 && a <= 8'h0A) begin
            v = a == 8'h08 ? x : a == 8'h09 ? y : z;
            return 8'(v / 16);
        end
        if (a >= 8'h0E && a <= 8'h13) begin
            idx = (int'(a) - 14) / 2;
            v = idx == 0 ? x : idx == 1 ? y : z;
            if (a[0] == 1'b0) return 8'(v % 256);
            return 8'(v / 256) + (v >= 12'h800 ? 8'hF0 : 8'h00);
        end
        return 8'h00;
    endfunction
    function automatic void m_wr(input logic [7:0] a, input logic [7:0] d);
        if (a == 8'h2C) m_filter = d;
        if (a == 8'h2D) m_power = d;
    endfunction
    task automatic spi_byte(input logic [7:0] tx);
        logic [7:0] r;
        logic       oe;
        oe = 0;
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            @(posedge sclk);
            #1;
            r[i] = miso;
            oe |= miso_oe;
            if (xfer_done) xd++;
            @(negedge sclk);
        end
        rxq.push_back(r);
        oeq.push_back(oe);
    endtask
    task automatic spi_start();
        rxq.delete();
        oeq.delete();
        xd = 0;
        cs = 0;
    endtask
    task automatic spi_stop();
        cs = 1;
        mosi = 0;
        @(posedge sclk);
        @(negedge sclk);
    endtask
    task automatic write1(input logic [7:0] a, input logic [7:0] d);
        spi_start();
        spi_byte(8'h0A);
        spi_byte(a);
        spi_byte(d);
        spi_stop();
        m_wr(a, d);
    endtask
    task automatic read_burst(input logic [7:0] a, input int n);
        spi_start();
        spi_byte(8'h0B);
        spi_byte(a);
        repeat (n) spi_byte(8'($urandom));
        spi_stop();
    endtask
    task automatic check_burst(input string name, input logic [7:0] a, input int n);
        for (int k = 0; k < n; k++) begin
            checks++;
            if (rxq[k+2] !== m_rd(8'(a + 8'(k)), acc_x, acc_y, acc_z)) begin
                errors++;
                $display("FAIL %s addr=%02h got=%02h exp=%02h", name, 8'(a + 8'(k)), rxq[k+2],
                         m_rd(8'(a + 8'(k)), acc_x, acc_y, acc_z));
            end
        end
        checks++;
        if (xd != n) begin
            errors++;
            $display("FAIL %s_xfer_done got=%0d exp=%0d", name, xd, n);
        end
    endtask
    task automatic check_regs(input string name);
        checks++;
        if (power_ctl !== m_power || filter_ctl !== m_filter || measuring !== (m_power[1:0] == 2'b10)) begin
            errors++;
            $display("FAIL %s power=%02h filter=%02h meas=%b exp power=%02h filter=%02h", name,
                     power_ctl, filter_ctl, measuring, m_power, m_filter);
        end
    endtask
    task automatic test_reset();
        repeat (2) @(negedge sclk);
        checks++;
        if ({miso, miso_oe, xfer_done, measuring} !== 4'b0000 || power_ctl !== 8'h00 || filter_ctl !== 8'h13) begin
            errors++;
            $display("FAIL reset miso=%b oe=%b xd=%b meas=%b power=%02h filter=%02h exp 0 0 0 0 00 13",
                     miso, miso_oe, xfer_done, measuring, power_ctl, filter_ctl);
        end
        rst = 0;
        @(negedge sclk);
        check_regs("after_reset");
    endtask
    task automatic test_devid();
        read_burst(8'h00, 3);
        check_burst("devid", 8'h00, 3);
        checks++;
        if (oeq[0] !== 1'b0 || oeq[1] !== 1'b0 || oeq[2] !== 1'b1) begin
            errors++;
            $display("FAIL devid_oe got cmd=%b addr=%b data=%b exp 0 0 1", oeq[0], oeq[1], oeq[2]);
        end
    endtask
    task automatic test_power_write();
        write1(8'h2D, 8'h02);
        check_regs("power_write");
        checks++;
        if (xd != 1) begin
            errors++;
            $display("FAIL power_write_xfer_done got=%0d exp=1", xd);
        end
        read_burst(8'h2D, 1);
        check_burst("power_readback", 8'h2D, 1);
        read_burst(8'h0B, 1);
        check_burst("status", 8'h0B, 1);
    endtask
    task automatic test_axes();
        acc_x = 12'hF85;
        acc_y = 12'h07A;
        acc_z = 12'h400;
        read_burst(8'h0E, 6);
        check_burst("axes_burst", 8'h0E, 6);
        read_burst(8'h08, 3);
        check_burst("axes_high", 8'h08, 3);
    endtask
    task automatic test_snapshot();
        acc_x = 12'hF85;
        spi_start();
        spi_byte(8'h0B);
        spi_byte(8'h0E);
        spi_byte(8'h00);
        acc_x = 12'h123;
        spi_byte(8'h00);
        spi_stop();
        checks++;
        if (rxq[2] !== 8'h85 || rxq[3] !== 8'hFF) begin
            errors++;
            $display("FAIL snapshot got=%02h %02h exp=85 FF", rxq[2], rxq[3]);
        end
        write1(8'h2D, 8'h00);
        read_burst(8'h0E, 6);
        check_burst("not_measuring", 8'h0E, 6);
    endtask
    task automatic test_ignore();
        spi_start();
        spi_byte(8'h55);
        spi_byte(8'h2D);
        spi_byte(8'hFF);
        spi_stop();
        checks++;
        if (oeq[0] | oeq[1] | oeq[2] || xd != 0) begin
            errors++;
            $display("FAIL ignore oe=%b%b%b xd=%0d exp oe=000 xd=0", oeq[0], oeq[1], oeq[2], xd);
        end
        check_regs("ignore_regs");
        write1(8'h2C, 8'hAA);
        read_burst(8'h2C, 1);
        check_burst("filter_readback", 8'h2C, 1);
        write1(8'h2E, 8'h11);
        check_regs("write_unmapped");
        checks++;
        if (xd != 1) begin
            errors++;
            $display("FAIL write_unmapped_xfer_done got=%0d exp=1", xd);
        end
    endtask
    task automatic test_abort();
        write1(8'h2D, 8'h02);
        spi_start();
        spi_byte(8'h0A);
        spi_byte(8'h2D);
        for (int i = 0; i < 5; i++) begin
            mosi = 1;
            @(posedge sclk);
            #1;
            if (xfer_done) xd++;
            @(negedge sclk);
        end
        spi_stop();
        check_regs("abort_regs");
        checks++;
        if (xd != 0) begin
            errors++;
            $display("FAIL abort_xfer_done got=%0d exp=0", xd);
        end
        write1(8'h2C, 8'h5A);
        check_regs("after_abort_write");
        spi_start();
        spi_byte(8'h0B);
        spi_byte(8'h2C);
        mosi = 0;
        repeat (3) @(posedge sclk);
        #2;
        rst = 1;
        #1;
        m_power = 8'h00;
        m_filter = 8'h13;
        checks++;
        if (power_ctl !== 8'h00 || filter_ctl !== 8'h13 || miso !== 1'b0 || miso_oe !== 1'b0 || xfer_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset power=%02h filter=%02h miso=%b oe=%b xd=%b exp 00 13 0 0 0",
                     power_ctl, filter_ctl, miso, miso_oe, xfer_done);
        end
        @(negedge sclk);
        cs = 1;
        @(negedge sclk);
        rst = 0;
        @(negedge sclk);
        read_burst(8'h00, 3);
        check_burst("after_reset_read", 8'h00, 3);
    endtask
    task automatic test_random();
        logic [7:0] tbl[8] = '{8'h00, 8'h08, 8'h0B, 8'h0E, 8'h11, 8'h2B, 8'hFE, 8'h2C};
        logic [7:0] a, d;
        int         n;
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                a = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'(8'h2B + 8'($urandom_range(0, 2)));
                n = $urandom_range(1, 3);
                spi_start();
                spi_byte(8'h0A);
                spi_byte(a);
                for (int k = 0; k < n; k++) begin
                    d = 8'($urandom);
                    if ($urandom_range(0, 1) == 1) d[1:0] = 2'b10;
                    spi_byte(d);
                    m_wr(8'(a + 8'(k)), d);
                end
                spi_stop();
                check_regs("rand_write");
                checks++;
                if (xd != n) begin
                    errors++;
                    $display("FAIL rand_write_xfer_done got=%0d exp=%0d", xd, n);
                end
            end else begin
                acc_x = 12'($urandom);
                acc_y = 12'($urandom);
                acc_z = 12'($urandom);
                a = tbl[$urandom_range(0, 7)];
                n = $urandom_range(1, 6);
                read_burst(a, n);
                check_burst("rand_read", a, n);
            end
        end
    endtask
    initial begin
        test_reset();
        test_devid();
        test_power_write();
        test_axes();
        test_snapshot();
        test_ignore();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/acl2_spi_responder.md
Name: acl2_spi_responder

Overview:
- Synthesizable SPI slave that emulates the ADXL362 (ACL2 Pmod) register protocol: command byte, address byte, then burst data with auto-increment.
- Acts as the far end of the on-board ACL2 SPI master. It serves as a loopback/sim target for the master and lets the design run with no physical sensor attached.
- Acceleration values come from input ports. POWER_CTL and FILTER_CTL written by the master are exported to the fabric.

Parameters:
DEVID_AD, 8'hAD, value returned at address 0x00
DEVID_MST, 8'h1D, value returned at address 0x01
PARTID, 8'hF2, value returned at address 0x02

Ports:
sclk  in  1  SPI clock; mode 0 (CPOL=0, CPHA=0); sole clock
rst  in  1  asynchronous, active-high reset
cs  in  1  chip select, active low
mosi  in  1  serial data from master, MSB first
miso  out  1  serial data to master, MSB first
miso_oe  out  1  high while the block is driving read data
acc_x, acc_y, acc_z  in  12 each  signed sample sources
power_ctl  out  8  register 0x2D
filter_ctl  out  8  register 0x2C
measuring  out  1  power_ctl[1:0]==2'b10
xfer_done  out  1  one-sclk pulse per completed data byte (read or write)

Behaviour:
- Reset: state=CMD, bitcnt=0, ptr=0, miso=0, miso_oe=0, xfer_done=0, power_ctl=8'h00, filter_ctl=8'h13, snapshots=0.
- Sampling and launch:
  - mosi is sampled on posedge sclk. All state, counters and registers update on posedge.
  - miso and miso_oe are registered on negedge sclk.
- cs high at a posedge: state<=CMD, bitcnt<=0, xfer_done<=0. Any partial byte is discarded. The following negedge clears miso_oe and sets miso=0.
- bitcnt is 3 bits and increments on every cs-low posedge. A byte completes on the posedge where bitcnt==7, and bitcnt wraps to 0.
- States:
  - CMD: byte completes with value 0x0A -> ADDR(write). Value 0x0B -> ADDR(read), and on that same posedge acc_x/y/z are captured into snapshots. Any other value -> IGNORE.
  - ADDR: byte completes -> ptr<=byte, DATA.
    - Read mode, same edge: tx_byte<=rd(ptr value just received), ptr<=byte+1.
  - DATA, read mode: on each byte completion, tx_byte<=rd(ptr), ptr<=ptr+1, and xfer_done pulses.
  - DATA, write mode: on each byte completion, wr(ptr,byte), ptr<=ptr+1, and xfer_done pulses.
  - IGNORE: hold until cs high. miso_oe=0.
- miso launch: on each negedge while in DATA read mode, miso<=tx_byte[7-bitcnt] and miso_oe=1. The master therefore sees bit7 on the first posedge after the address byte.
- ptr is 8 bits and wraps 0xFF->0x00.
- Read map rd(a):
  - 0x00/0x01/0x02 -> the parameter values.
  - 0x08/0x09/0x0A -> x/y/z[11:4].
  - 0x0B STATUS -> {7'b0, measuring}.
  - 0x0E/0x0F -> x[7:0] and {{4{x[11]}}, x[11:8]}.
  - 0x10/0x11 -> the same split for y.
  - 0x12/0x13 -> the same split for z.
  - 0x2C -> filter_ctl. 0x2D -> power_ctl.
  - Any other address -> 0x00.
  - All data registers (0x08–0x0A, 0x0E–0x13) read 0x00 when measuring=0.
  - All data comes from the snapshot. A burst is therefore coherent even if acc_* change mid-transfer.
- Write map wr(a): only 0x2C and 0x2D are writable. Writes to any other address are dropped silently but still pulse xfer_done. A write takes effect on the completing posedge, and power_ctl/measuring update the same edge.
- A read of 0x2C/0x2D returns the value at the time the byte is loaded into tx_byte. Write and read cannot occur in the same transaction.
- rst asserted mid-transaction: everything returns to reset values at once; the master must reassert cs to restart.

Test Plan:
- Reset, then read 0x0B,0x00 with 3 bytes -> miso returns AD, 1D, F2; xfer_done pulses 3 times; miso_oe is low during the command and address bytes.
- Write 0x0A,0x2D,0x02, then read 0x0B,0x2D -> returns 0x02; power_ctl=0x02; measuring=1.
- measuring=1, acc_x=12'hF85, acc_y=12'h07A, acc_z=12'h400; burst read from 0x0E, 6 bytes -> 85 FF 7A 00 00 04.
- Burst read from 0x0E with acc_x changed to 12'h123 after the first byte -> the second byte is still FF (snapshot); with measuring=0 the same burst returns all 00.
- Unknown command 0x55 followed by 16 clocks -> miso_oe stays 0 and no register changes; write 0x0A,0x2C,0xAA then read back -> 0xAA; write 0x0A,0x2E,0x11 -> no output change.
- cs raised after 5 bits of a write data byte -> the register is unchanged and no xfer_done pulse occurs; asserting rst mid-burst -> power_ctl=0x00, filter_ctl=0x13, miso=0.
